// File: rtl/ro_freq_meter_pkg.sv
// Shared types and constants for the ring-oscillator frequency meter.
// The state encoding matches the tile's clock-source selector.
package ro_freq_meter_pkg;

  localparam int unsigned GATE_LOG2_W = 5;
  localparam int unsigned ARM_CYCLES  = 3;
  localparam int unsigned ARM_CNT_W   = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    GATE = 2'd2
  } meter_state_e;

  // Limit the requested gate exponent to the largest supported one.
  function automatic logic [GATE_LOG2_W-1:0] clamp_gate(
    input logic [GATE_LOG2_W-1:0] g,
    input int unsigned            gmax
  );
    if (32'(g) > gmax) return GATE_LOG2_W'(gmax);
    return g;
  endfunction

endpackage

// File: rtl/ro_sync_edge.sv
// Two-flop synchroniser followed by a rising-edge detector.
// rise_c is combinational from the last two flops.
module ro_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic d_in,
  output logic rise_c
);

  logic s1_q, s2_q, s3_q;
  logic s1_d, s2_d, s3_d;

  always_comb begin
    s1_d = d_in;
    s2_d = s1_q;
    s3_d = s2_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
      s3_q <= s3_d;
    end
  end

  assign rise_c = s2_q & ~s3_q;

endmodule

// File: rtl/ro_freq_meter.sv
// Multi-channel ring-oscillator frequency meter: counts synchronised rising
// edges of one selected oscillator over a 2^g clk-cycle gate window.
module ro_freq_meter
  import ro_freq_meter_pkg::*;
#(
  parameter int unsigned N_CH     = 8,
  parameter int unsigned CNT_W    = 16,
  parameter int unsigned GATE_MAX = 20
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_CH-1:0]            osc_in,
  input  logic [$clog2(N_CH)-1:0]    ch_sel,
  input  logic [GATE_LOG2_W-1:0]     gate_log2,
  input  logic                       cont,
  input  logic                       start,
  output logic                       busy,
  output logic                       done,
  output logic [CNT_W-1:0]           count,
  output logic                       overflow
);

  localparam int unsigned CH_W   = $clog2(N_CH);
  localparam int unsigned GATE_W = GATE_MAX + 1;

  meter_state_e           state_q, state_d;
  logic [CH_W-1:0]        ch_q, ch_d;
  logic [GATE_LOG2_W-1:0] g_q, g_d;
  logic [ARM_CNT_W-1:0]   arm_q, arm_d;
  logic [GATE_W-1:0]      gcnt_q, gcnt_d;
  logic [CNT_W-1:0]       ecnt_q, ecnt_d;
  logic                   run_ovf_q, run_ovf_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic [CNT_W-1:0]       count_q, count_d;
  logic                   overflow_q, overflow_d;

  logic                   osc_sel;
  logic                   rise_c;
  logic [GATE_W-1:0]      gate_term;
  logic [CNT_W-1:0]       ecnt_inc;
  logic                   ovf_inc;

  assign osc_sel = osc_in[ch_q];

  ro_sync_edge u_sync (
    .clk    (clk),
    .rst    (rst),
    .d_in   (osc_sel),
    .rise_c (rise_c)
  );

  // Last gate cycle index; g_q never exceeds GATE_MAX so this cannot wrap.
  assign gate_term = (GATE_W'(1) << g_q) - GATE_W'(1);

  // Saturating edge count including this cycle's edge.
  always_comb begin
    ecnt_inc = ecnt_q;
    ovf_inc  = run_ovf_q;
    if (rise_c) begin
      if (&ecnt_q) ovf_inc = 1'b1;
      else         ecnt_inc = ecnt_q + CNT_W'(1);
    end
  end

  always_comb begin
    state_d    = state_q;
    ch_d       = ch_q;
    g_d        = g_q;
    arm_d      = arm_q;
    gcnt_d     = gcnt_q;
    ecnt_d     = ecnt_q;
    run_ovf_d  = run_ovf_q;
    done_d     = 1'b0;
    count_d    = count_q;
    overflow_d = overflow_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          ch_d    = ch_sel;
          g_d     = clamp_gate(gate_log2, GATE_MAX);
          arm_d   = '0;
          state_d = ARM;
        end
      end
      ARM: begin
        ecnt_d    = '0;
        run_ovf_d = 1'b0;
        gcnt_d    = '0;
        arm_d     = arm_q + ARM_CNT_W'(1);
        if (arm_q == ARM_CNT_W'(ARM_CYCLES - 1)) state_d = GATE;
      end
      GATE: begin
        ecnt_d    = ecnt_inc;
        run_ovf_d = ovf_inc;
        gcnt_d    = gcnt_q + GATE_W'(1);
        if (gcnt_q == gate_term) begin
          count_d    = ecnt_inc;
          overflow_d = ovf_inc;
          done_d     = 1'b1;
          ecnt_d     = '0;
          run_ovf_d  = 1'b0;
          gcnt_d     = '0;
          arm_d      = '0;
          if (cont) begin
            // Same channel needs no resync flush, so gating restarts at once.
            ch_d    = ch_sel;
            g_d     = clamp_gate(gate_log2, GATE_MAX);
            state_d = (ch_sel == ch_q) ? GATE : ARM;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      ch_q       <= '0;
      g_q        <= '0;
      arm_q      <= '0;
      gcnt_q     <= '0;
      ecnt_q     <= '0;
      run_ovf_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ch_q       <= ch_d;
      g_q        <= g_d;
      arm_q      <= arm_d;
      gcnt_q     <= gcnt_d;
      ecnt_q     <= ecnt_d;
      run_ovf_q  <= run_ovf_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign count    = count_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_ro_freq_meter.sv
// Scoreboard bench for ro_freq_meter: each scenario queues the expected
// result (done cycle, count, overflow) and a negedge monitor checks every done.
module tb_ro_freq_meter;

  localparam int N_CH     = 8;
  localparam int CNT_W    = 8;
  localparam int GATE_MAX = 10;
  localparam int CH_W     = $clog2(N_CH);
  localparam int CNT_MAX  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst;
  logic [N_CH-1:0]  osc_in;
  logic [CH_W-1:0]  ch_sel;
  logic [4:0]       gate_log2;
  logic             cont;
  logic             start;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] count;
  logic             overflow;

  ro_freq_meter #(.N_CH(N_CH), .CNT_W(CNT_W), .GATE_MAX(GATE_MAX)) dut (
    .clk       (clk),
    .rst       (rst),
    .osc_in    (osc_in),
    .ch_sel    (ch_sel),
    .gate_log2 (gate_log2),
    .cont      (cont),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .count     (count),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  int cyc  = 0;
  int ncyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) ncyc <= ncyc + 1;

  // Oscillators change on the falling edge; half == 0 selects manual drive.
  int              half [N_CH];
  logic [N_CH-1:0] osc_man;
  always_comb begin
    for (int i = 0; i < N_CH; i++)
      osc_in[i] = (half[i] == 0) ? osc_man[i] : 1'((ncyc / half[i]) % 2);
  end

  typedef struct {
    int cyc;
    int cnt;
    int ovf;
  } exp_t;
  exp_t exp_q[$];

  int tests_run    = 0;
  int tests_failed = 0;

  always @(negedge clk) begin
    exp_t e;
    if (done === 1'b1) begin
      if (exp_q.size() == 0) begin
        tests_run++;
        tests_failed++;
        $display("FAIL unexpected_done: done at cycle %0d count=%0d, none expected", cyc, count);
      end else begin
        e = exp_q.pop_front();
        tests_run++;
        if (cyc !== e.cyc) begin
          tests_failed++;
          $display("FAIL done_cycle: got cycle %0d, expected %0d", cyc, e.cyc);
        end
        tests_run++;
        if (int'(count) !== e.cnt) begin
          tests_failed++;
          $display("FAIL count: got %0d, expected %0d (cycle %0d)", count, e.cnt, cyc);
        end
        tests_run++;
        if (int'(overflow) !== e.ovf) begin
          tests_failed++;
          $display("FAIL overflow: got %0d, expected %0d (cycle %0d)", overflow, e.ovf, cyc);
        end
      end
    end
  end

  task automatic wait_until(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  function automatic int gate_len(input int g);
    return 1 << ((g > GATE_MAX) ? GATE_MAX : g);
  endfunction

  task automatic push_exp(input int c, input int n, input int o);
    exp_t e;
    e.cyc = c;
    e.cnt = n;
    e.ovf = o;
    exp_q.push_back(e);
  endtask

  // Start is held for exactly one cycle; c0 is the accepting cycle.
  task automatic start_meas(input int ch, input int g, input bit c, output int c0);
    @(negedge clk);
    ch_sel    = CH_W'(ch);
    gate_log2 = 5'(g);
    cont      = c;
    start     = 1'b1;
    c0        = cyc;
    @(negedge clk);
    start     = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    tests_run++;
    if (busy !== 1'b0 || done !== 1'b0 || count !== '0 || overflow !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_state: busy=%b done=%b count=%0d ovf=%b, expected all 0",
               busy, done, count, overflow);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single();
    int c0;
    half[3] = 4;
    start_meas(3, 6, 1'b0, c0);
    push_exp(c0 + 4 + 64, 8, 0);
    wait_until(c0 + 30);
    tests_run++;
    if (busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL single_busy_mid: busy=%b, expected 1", busy);
    end
    wait_until(c0 + 69);
    tests_run++;
    if (busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL single_busy_after: busy=%b, expected 0", busy);
    end
    wait_until(c0 + 90);
    tests_run++;
    if (exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL single_missing_done: %0d results outstanding, expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_saturate();
    int c0;
    int gl;
    int edges;
    half[0] = 1;
    gl    = gate_len(20);
    edges = gl / 2;
    start_meas(0, 20, 1'b0, c0);
    push_exp(c0 + 4 + gl, (edges > CNT_MAX) ? CNT_MAX : edges, (edges > CNT_MAX) ? 1 : 0);
    wait_until(c0 + 4 + gl + 3);
    start_meas(0, 4, 1'b0, c0);
    push_exp(c0 + 4 + 16, 8, 0);
    wait_until(c0 + 30);
    tests_run++;
    if (exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL saturate_missing_done: %0d results outstanding, expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_clamp_ignore_start();
    int c0;
    int gl;
    gl = gate_len(31);
    start_meas(3, 31, 1'b0, c0);
    push_exp(c0 + 4 + gl, gl / 8, 0);
    wait_until(c0 + 500);
    ch_sel    = CH_W'(0);
    gate_log2 = 5'd2;
    start     = 1'b1;
    @(negedge clk);
    start     = 1'b0;
    wait_until(c0 + 4 + gl + 12);
    tests_run++;
    if (exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL clamp_missing_done: %0d results outstanding, expected 0", exp_q.size());
      exp_q.delete();
    end
    tests_run++;
    if (busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL clamp_busy_after: busy=%b, expected 0", busy);
    end
  endtask

  task automatic test_continuous();
    int c0;
    half[1] = 4;
    half[2] = 8;
    start_meas(1, 5, 1'b1, c0);
    push_exp(c0 + 36, 4, 0);
    push_exp(c0 + 68, 4, 0);
    push_exp(c0 + 100, 4, 0);
    push_exp(c0 + 132, 4, 0);
    push_exp(c0 + 167, 2, 0);
    wait_until(c0 + 101);
    ch_sel = CH_W'(2);
    wait_until(c0 + 133);
    cont = 1'b0;
    wait_until(c0 + 168);
    tests_run++;
    if (busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL cont_busy_after: busy=%b, expected 0", busy);
    end
    wait_until(c0 + 220);
    tests_run++;
    if (exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL cont_missing_done: %0d results outstanding, expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset_mid();
    int c0;
    start_meas(3, 6, 1'b0, c0);
    wait_until(c0 + 20);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    tests_run++;
    if (busy !== 1'b0 || done !== 1'b0 || count !== '0 || overflow !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_mid: busy=%b done=%b count=%0d ovf=%b, expected all 0",
               busy, done, count, overflow);
    end
    wait_until(c0 + 90);
    start_meas(3, 6, 1'b0, c0);
    push_exp(c0 + 68, 8, 0);
    wait_until(c0 + 80);
    tests_run++;
    if (exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL reset_mid_missing_done: %0d results outstanding, expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  // Rises at cycles 1 (lands in ARM), 10, 17 (lands on last gate cycle), 19 (after).
  task automatic test_edge_boundary();
    int c0;
    half[5]    = 0;
    osc_man[5] = 1'b0;
    start_meas(5, 4, 1'b0, c0);
    push_exp(c0 + 20, 2, 0);
    for (int k = 1; k <= 24; k++) begin
      wait_until(c0 + k);
      osc_man[5] = (k == 1 || k == 10 || k == 17 || k == 19);
    end
    wait_until(c0 + 32);
    tests_run++;
    if (exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL edge_missing_done: %0d results outstanding, expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    for (int i = 0; i < N_CH; i++) half[i] = 0;
    osc_man   = '0;
    rst       = 1'b1;
    ch_sel    = '0;
    gate_log2 = '0;
    cont      = 1'b0;
    start     = 1'b0;

    test_reset();
    test_single();
    test_saturate();
    test_clamp_ignore_start();
    test_continuous();
    test_reset_mid();
    test_edge_boundary();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
